maj_net_tt_engine: RTL and testbench



---
 rtl/maj_net_tt_engine_if.sv | 33 +++
 rtl/maj_net_tt_engine.sv | 164 ++++++++++++++++
 tb/tb_maj_net_tt_engine.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/maj_net_tt_engine_if.sv
// Bus bundle for the majority-network truth-table engine: program port,
// sweep control (start/busy/done), the truth-table result and FSM debug state.
interface maj_net_tt_engine_if #(
  parameter int NIN   = 7,
  parameter int NODES = 8
);
  localparam int TTW  = 1 << NIN;
  localparam int SELW = $clog2(1 + NIN + NODES);
  localparam int OPW  = SELW + 1;
  localparam int AW   = $clog2(NODES);
  localparam int CW   = $clog2(NODES + 1);

  logic              prog_we;
  logic [AW-1:0]     prog_addr;
  logic [3*OPW-1:0]  prog_data;
  logic [CW-1:0]     num_nodes;
  logic [OPW-1:0]    out_op;
  logic              start;
  logic              busy;
  logic              done;
  logic [TTW-1:0]    tt;
  logic [1:0]        dbg_state;

  modport master (
    output prog_we, prog_addr, prog_data, num_nodes, out_op, start,
    input  busy, done, tt, dbg_state
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, num_nodes, out_op, start,
    output busy, done, tt, dbg_state
  );
endinterface

// File: rtl/maj_net_tt_engine.sv
// Programmable MAJ3 network evaluator: sweeps all 2^NIN minterms, evaluating
// one node per cycle, and assembles the full truth table of the output operand.
module maj_net_tt_engine #(
  parameter int NIN   = 7,
  parameter int NODES = 8
) (
  input logic            clk,
  input logic            rst,
  maj_net_tt_engine_if.slave bus
);
  localparam int TTW  = 1 << NIN;
  localparam int SELW = $clog2(1 + NIN + NODES);
  localparam int OPW  = SELW + 1;
  localparam int AW   = $clog2(NODES);
  localparam int CW   = $clog2(NODES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_CAPT = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [NIN-1:0]    m_q, m_d;
  logic [AW-1:0]     k_q, k_d;
  logic [CW-1:0]     n_q, n_d;
  logic [OPW-1:0]    out_q, out_d;
  logic [TTW-1:0]    tt_q, tt_d;
  logic [NODES-1:0]  node_q, node_d;
  logic [3*OPW-1:0]  prog_q [NODES];
  logic [3*OPW-1:0]  prog_d [NODES];

  logic [CW-1:0]     n_start;
  logic [3*OPW-1:0]  cur_prog;
  logic              op_a, op_b, op_c;
  logic              node_val;
  logic              capt_val;
  logic              last_node;
  logic              last_mt;

  // Operand value: sel 0 -> 0, 1..NIN -> x[sel-1], then node[sel-NIN-1].
  // Nodes at index >= lim (forward/self refs, or beyond the active count
  // when sampling the output) read 0 before inversion.
  function automatic logic op_val(input logic [OPW-1:0]   op,
                                  input logic [NIN-1:0]   mt,
                                  input logic [NODES-1:0] nv,
                                  input int               lim);
    logic v;
    v = 1'b0;
    for (int i = 0; i < NIN; i++) begin
      if (int'(op[SELW-1:0]) == i + 1) v = mt[i];
    end
    for (int j = 0; j < NODES; j++) begin
      if (int'(op[SELW-1:0]) == NIN + 1 + j && j < lim) v = nv[j];
    end
    return v ^ op[OPW-1];
  endfunction

  always_comb begin
    n_start = (int'(bus.num_nodes) > NODES) ? CW'(NODES) : bus.num_nodes;
    cur_prog = '0;
    for (int j = 0; j < NODES; j++) begin
      if (int'(k_q) == j) cur_prog = prog_q[j];
    end
    op_a      = op_val(cur_prog[3*OPW-1 -: OPW], m_q, node_q, int'(k_q));
    op_b      = op_val(cur_prog[2*OPW-1 -: OPW], m_q, node_q, int'(k_q));
    op_c      = op_val(cur_prog[OPW-1:0],        m_q, node_q, int'(k_q));
    node_val  = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
    capt_val  = op_val(out_q, m_q, node_q, int'(n_q));
    last_node = (int'(k_q) == int'(n_q) - 1);
    last_mt   = (m_q == {NIN{1'b1}});
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = (n_start == '0) ? S_CAPT : S_EVAL;
      S_EVAL: if (last_node) state_d = S_CAPT;
      S_CAPT: begin
        if (last_mt)           state_d = S_FIN;
        else if (n_q == '0)    state_d = S_CAPT;
        else                   state_d = S_EVAL;
      end
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake: start is accepted only in IDLE; busy is high in EVAL/CAPT,
  // done pulses for exactly the FIN cycle, and tt is final from done until
  // the next accepted start.
  always_comb begin
    bus.busy      = (state_q == S_EVAL) || (state_q == S_CAPT);
    bus.done      = (state_q == S_FIN);
    bus.tt        = tt_q;
    bus.dbg_state = state_q;
  end

  always_comb begin
    m_d    = m_q;
    k_d    = k_q;
    n_d    = n_q;
    out_d  = out_q;
    tt_d   = tt_q;
    node_d = node_q;
    for (int j = 0; j < NODES; j++) prog_d[j] = prog_q[j];
    case (state_q)
      S_IDLE: begin
        // A write and a start in the same cycle both land; the sweep's first
        // EVAL cycle already sees the new entry.
        for (int j = 0; j < NODES; j++) begin
          if (bus.prog_we && int'(bus.prog_addr) == j) prog_d[j] = bus.prog_data;
        end
        if (bus.start) begin
          n_d   = n_start;
          out_d = bus.out_op;
          m_d   = '0;
          k_d   = '0;
          tt_d  = '0;
        end
      end
      S_EVAL: begin
        for (int j = 0; j < NODES; j++) begin
          if (int'(k_q) == j) node_d[j] = node_val;
        end
        k_d = last_node ? '0 : k_q + AW'(1);
      end
      S_CAPT: begin
        tt_d[m_q] = capt_val;
        if (!last_mt) begin
          m_d = m_q + NIN'(1);
          k_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q    <= '0;
      k_q    <= '0;
      n_q    <= '0;
      out_q  <= '0;
      tt_q   <= '0;
      node_q <= '0;
      for (int j = 0; j < NODES; j++) prog_q[j] <= '0;
    end else begin
      m_q    <= m_d;
      k_q    <= k_d;
      n_q    <= n_d;
      out_q  <= out_d;
      tt_q   <= tt_d;
      node_q <= node_d;
      for (int j = 0; j < NODES; j++) prog_q[j] <= prog_d[j];
    end
  end
endmodule

// File: tb/tb_maj_net_tt_engine.sv
// Self-checking bench for maj_net_tt_engine: table vectors, directed
// multi-cycle sequences and randomized programs against a behavioural model.
module tb_maj_net_tt_engine;
  localparam int NIN   = 7;
  localparam int NODES = 8;
  localparam int TTW   = 128;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  logic [14:0]  mdl_prog [8];
  logic [127:0] exp_q [$];

  typedef struct {
    int           n;
    logic [4:0]   op;
    logic [127:0] exp;
  } vec_t;
  vec_t tbl [8];

  maj_net_tt_engine_if #(.NIN(NIN), .NODES(NODES)) bus ();

  maj_net_tt_engine #(.NIN(NIN), .NODES(NODES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference ----------------
  function automatic int opv(input logic [4:0] op, input int m, input bit nv[8], input int lim);
    int sel;
    int v;
    sel = int'(op[3:0]);
    v = 0;
    if (sel >= 1 && sel <= 7)              v = (m >> (sel - 1)) & 1;
    else if (sel >= 8 && (sel - 8) < lim)  v = int'(nv[sel - 8]);
    return v ^ int'(op[4]);
  endfunction

  function automatic logic [127:0] ref_tt(input int n, input logic [4:0] op);
    logic [127:0] r;
    bit nv [8];
    int a, b, c;
    r = '0;
    for (int m = 0; m < TTW; m++) begin
      for (int j = 0; j < 8; j++) nv[j] = 1'b0;
      for (int k = 0; k < n; k++) begin
        a = opv(mdl_prog[k][14:10], m, nv, k);
        b = opv(mdl_prog[k][9:5],   m, nv, k);
        c = opv(mdl_prog[k][4:0],   m, nv, k);
        nv[k] = (a + b + c) >= 2;
      end
      r[m] = opv(op, m, nv, n) != 0;
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_prog(input int addr, input logic [14:0] data);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 3'(addr);
    bus.prog_data = data;
    @(negedge clk);
    bus.prog_we   = 1'b0;
    if (addr < NODES) mdl_prog[addr] = data;
  endtask

  function automatic logic [14:0] maj(input int a, input int b, input int c);
    return {5'(a), 5'(b), 5'(c)};
  endfunction

  // Launch a sweep; optionally write node0 in the start cycle (we0) and
  // inject a start/prog_we pulse at cycle inj while busy.
  task automatic run_sweep(input int n, input logic [4:0] op, input int inj,
                           input bit we0, input logic [14:0] d0, input string tag);
    int c;
    bit seen;
    int nc;
    logic [127:0] exp;
    nc = (n > NODES) ? NODES : n;
    if (we0) mdl_prog[0] = d0;
    exp_q.push_back(ref_tt(nc, op));
    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_nodes = 4'(n);
    bus.out_op    = op;
    if (we0) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = 3'd0;
      bus.prog_data = d0;
    end
    @(posedge clk);
    c = 0;
    seen = 1'b0;
    while (!seen && c < 1300) begin
      @(negedge clk);
      c++;
      bus.start   = 1'b0;
      bus.prog_we = 1'b0;
      if (c == 1) check({tag, " busy_rise"}, 128'(bus.busy), 128'(1));
      if (c == inj) begin
        bus.start     = 1'b1;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 3'd0;
        bus.prog_data = maj(1, 1, 1);
        bus.num_nodes = 4'd0;
        bus.out_op    = 5'd1;
      end
      if (bus.done) seen = 1'b1;
    end
    check({tag, " done_seen"}, 128'(seen), 128'(1));
    check({tag, " length"}, 128'(c), 128'(TTW * (nc + 1) + 1));
    check({tag, " busy_at_done"}, 128'(bus.busy), 128'(0));
    exp = exp_q.pop_front();
    check({tag, " tt"}, bus.tt, exp);
    @(negedge clk);
    check({tag, " done_pulse"}, 128'(bus.done), 128'(0));
    check({tag, " tt_stable"}, bus.tt, exp);
  endtask

  function automatic logic [4:0] rand_op(input int n);
    logic [4:0] o;
    o[4]   = 1'($urandom_range(0, 1));
    o[3:0] = 4'($urandom_range(0, 7 + n));
    return o;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int c;
    int done_cnt;
    n_checks = 0;
    n_err    = 0;
    for (int j = 0; j < 8; j++) mdl_prog[j] = '0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.num_nodes = '0;
    bus.out_op    = '0;
    bus.start     = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst busy", 128'(bus.busy), 128'(0));
    check("rst done", 128'(bus.done), 128'(0));
    check("rst tt", bus.tt, '0);
    run_sweep(0, 5'd0, 0, 1'b0, '0, "rst_sweep");
    check("rst_sweep const0", bus.tt, '0);

    // Table-driven pass-through vectors (no nodes)
    tbl[0] = '{0, 5'b00001, {16{8'hAA}}};
    tbl[1] = '{0, 5'b10000, {128{1'b1}}};
    tbl[2] = '{0, 5'b00010, {16{8'hCC}}};
    tbl[3] = '{0, 5'b00011, {16{8'hF0}}};
    tbl[4] = '{0, 5'b10100, {8{16'h00FF}}};
    tbl[5] = '{0, 5'b00101, {4{32'hFFFF0000}}};
    tbl[6] = '{0, 5'b00110, {2{64'hFFFFFFFF00000000}}};
    tbl[7] = '{0, 5'b10111, {64'h0, {64{1'b1}}}};
    for (int i = 0; i < 8; i++) begin
      run_sweep(tbl[i].n, tbl[i].op, 0, 1'b0, '0, "tbl");
      check($sformatf("tbl[%0d] tt", i), bus.tt, tbl[i].exp);
    end

    // Single node: MAJ(x0,x1,x6)
    write_prog(0, maj(1, 2, 7));
    run_sweep(1, 5'd8, 0, 1'b0, '0, "single");
    check("single tt[03]", 128'(bus.tt[7'h03]), 128'(1));
    check("single tt[41]", 128'(bus.tt[7'h41]), 128'(1));
    check("single tt[43]", 128'(bus.tt[7'h43]), 128'(1));
    check("single tt[01]", 128'(bus.tt[7'h01]), 128'(0));
    check("single tt[40]", 128'(bus.tt[7'h40]), 128'(0));

    // Same-cycle write + start: node0 becomes MAJ(x0,x0,x2) = x0
    run_sweep(1, 5'd8, 0, 1'b1, maj(1, 1, 3), "we_start");
    check("we_start tt", bus.tt, {16{8'hAA}});

    // Six-node network
    write_prog(0, maj(1, 2, 7));
    write_prog(1, maj(2, 3, 8));
    write_prog(2, maj(2, 3, 4));
    write_prog(3, maj(4, 6, 8));
    write_prog(4, maj(5, 9, 11));
    write_prog(5, maj(1, 10, 12));
    run_sweep(6, 5'd13, 0, 1'b0, '0, "six");
    check("six tt const", bus.tt, 128'hfeeaece8eee8ec80fec8e888e8c8a880);

    // Forward reference, with start/prog_we pulsed mid-sweep
    write_prog(0, maj(1, 2, 9));
    write_prog(1, maj(1, 1, 1));
    run_sweep(2, 5'd8, 50, 1'b0, '0, "fwd");
    check("fwd tt const", bus.tt, {32{4'h8}});
    run_sweep(2, 5'd8, 0, 1'b0, '0, "fwd_rerun");
    check("fwd_rerun tt const", bus.tt, {32{4'h8}});

    // Clamp num_nodes=15 to 8
    for (int j = 0; j < 8; j++) write_prog(j, {rand_op(j), rand_op(j), rand_op(j)});
    run_sweep(15, 5'd15, 0, 1'b0, '0, "clamp");

    // Randomized programs
    for (int r = 0; r < 8; r++) begin
      int n;
      for (int j = 0; j < 8; j++) write_prog(j, {rand_op(8), rand_op(8), rand_op(8)});
      n = $urandom_range(0, 6);
      run_sweep(n, rand_op(n), 0, 1'($urandom_range(0, 1)),
                {rand_op(8), rand_op(8), rand_op(8)}, $sformatf("rand%0d", r));
    end

    // Reset mid-sweep of the six-node network
    write_prog(0, maj(1, 2, 7));
    write_prog(1, maj(2, 3, 8));
    write_prog(2, maj(2, 3, 4));
    write_prog(3, maj(4, 6, 8));
    write_prog(4, maj(5, 9, 11));
    write_prog(5, maj(1, 10, 12));
    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_nodes = 4'd6;
    bus.out_op    = 5'd13;
    @(posedge clk);
    c = 0;
    while (c < 300) begin
      @(negedge clk);
      c++;
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 8; j++) mdl_prog[j] = '0;
    check("midrst busy", 128'(bus.busy), 128'(0));
    check("midrst done", 128'(bus.done), 128'(0));
    check("midrst tt", bus.tt, '0);
    done_cnt = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("midrst no_done", 128'(done_cnt), 128'(0));
    run_sweep(6, 5'd13, 0, 1'b0, '0, "post_rst");
    check("post_rst tt zero", bus.tt, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
